// File: rtl/sp_ram_bist_pkg.sv
// sp_ram_bist shared types: FSM states, RAM op codes
// and the March C- element table.
package sp_ram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    R0,
    R1,
    W0,
    W1
  } op_t;

  typedef struct packed {
    logic down;
    logic pair;
    op_t  op0;
    op_t  op1;
  } elem_t;

  localparam int NUM_ELEM = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  localparam elem_t [0:NUM_ELEM-1] MARCH = '{
    '{1'b0, 1'b0, W0, W0},
    '{1'b0, 1'b1, R0, W1},
    '{1'b0, 1'b1, R1, W0},
    '{1'b1, 1'b1, R0, W1},
    '{1'b1, 1'b1, R1, W0},
    '{1'b0, 1'b0, R0, R0}
  };

  function automatic logic is_write(input op_t op);
    return op[1];
  endfunction

  function automatic logic is_one(input op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/sp_ram_bist_if.sv
// Single-port RAM bus: initiator drives en/addr/wdata/we/be,
// target returns rdata one cycle after a read.
interface sp_ram_bist_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output en, addr, wdata, we, be,
    input  rdata
  );

  modport slave (
    input  en, addr, wdata, we, be,
    output rdata
  );
endinterface

// File: rtl/sp_ram_bist_cmp.sv
// Read-compare pipeline: capture expected word on a read,
// compare against rdata next cycle, hold first failing address.
module sp_ram_bist_cmp #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  logic                  pend_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
    end else if (clear) begin
      pend_q    <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
    end else begin
      pend_q <= rd_valid;
      if (rd_valid) begin
        exp_q  <= exp_data;
        addr_q <= rd_addr;
      end
      if (pend_q && !fail &&
          (ram_rdata != exp_q)) begin
        fail      <= 1'b1;
        fail_addr <= addr_q;
      end
    end
  end

endmodule

// File: rtl/sp_ram_bist.sv
// March C- BIST engine driving a single-port RAM;
// bus outputs are registered, results come from the compare stage.
module sp_ram_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int          RAM_SIZE   = 32768,
  parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] PATTERN    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  sp_ram_bist_if.master         ram
);

  localparam int N  = RAM_SIZE / 4;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] LAST = WW'(N - 1);

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [WW-1:0]         word_q, word_d;
  logic                  slot_q, slot_d;
  logic                  fin_q, fin_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;

  elem_t                 cur;
  op_t                   op;
  logic [2:0]            nxt_e;
  logic                  last_word;
  logic                  clear;
  logic [DATA_WIDTH-1:0] data;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      elem_q  <= '0;
      word_q  <= '0;
      slot_q  <= 1'b0;
      fin_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      fin_q   <= fin_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    word_d    = word_q;
    slot_d    = slot_q;
    fin_d     = fin_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    exp_d     = '0;
    clear     = 1'b0;
    cur       = MARCH[elem_q];
    op        = slot_q ? cur.op1 : cur.op0;
    nxt_e     = elem_q + 3'd1;
    last_word = cur.down ? (word_q == '0)
                         : (word_q == LAST);
    data      = is_one(op) ? ~PATTERN : PATTERN;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          elem_d  = '0;
          word_d  = '0;
          slot_d  = 1'b0;
          fin_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (fin_q) begin
          state_d = DRAIN;
          fin_d   = 1'b0;
        end else begin
          en_d    = 1'b1;
          we_d    = is_write(op);
          addr_d  = {word_q, 2'b00};
          wdata_d = is_write(op) ? data : '0;
          exp_d   = data;
          if (cur.pair && !slot_q) begin
            slot_d = 1'b1;
          end else begin
            slot_d = 1'b0;
            if (!last_word) begin
              word_d = cur.down ? word_q - 1'b1
                                : word_q + 1'b1;
            end else if (elem_q == LAST_ELEM) begin
              fin_d  = 1'b1;
              elem_d = '0;
              word_d = '0;
            end else begin
              // each element starts at its own end of the array
              elem_d = nxt_e;
              word_d = MARCH[nxt_e].down ? LAST : '0;
            end
          end
        end
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  sp_ram_bist_cmp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .clk      (clk),
    .rst_n    (rstn_i),
    .clear    (clear),
    .rd_valid (en_q & ~we_q),
    .exp_data (exp_q),
    .rd_addr  (addr_q),
    .ram_rdata(ram.rdata),
    .fail     (fail_o),
    .fail_addr(fail_addr_o)
  );

  assign busy_o    = (state_q == RUN) ||
                     (state_q == DRAIN);
  assign done_o    = (state_q == DONE);
  assign ram.en    = en_q;
  assign ram.we    = we_q;
  assign ram.addr  = addr_q;
  assign ram.wdata = wdata_q;
  assign ram.be    = {(DATA_WIDTH/8){en_q}};

endmodule

// File: tb/tb_sp_ram_bist.sv
// Bench for sp_ram_bist: faulty RAM models plus a march-level
// reference that predicts bus ops and the first failing address.
module tb_sp_ram_bist;

  localparam int RS = 64;
  localparam int N  = 16;
  localparam int AW = 6;
  localparam logic [31:0] PAT1 = 32'h5555_5555;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  sp_ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) r0 ();
  sp_ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) r1 ();

  logic busy0, done0, fail0;
  logic busy1, done1, fail1;
  logic [AW-1:0] fa0, fa1;

  sp_ram_bist #(.RAM_SIZE(RS)) dut0 (
    .clk(clk), .rstn_i(rstn), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .fail_o(fail0),
    .fail_addr_o(fa0), .ram(r0)
  );

  sp_ram_bist #(.RAM_SIZE(RS), .PATTERN(PAT1)) dut1 (
    .clk(clk), .rstn_i(rstn), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .fail_o(fail1),
    .fail_addr_o(fa1), .ram(r1)
  );

  // stuck-at-0 (z) and stuck-at-1 (o) bit masks per word
  logic [31:0] m0 [N];
  logic [31:0] m1 [N];
  logic [31:0] z0 [N];
  logic [31:0] o0 [N];
  logic [31:0] z1 [N];

  always @(posedge clk) begin
    if (r0.en) begin
      if (r0.we)
        m0[r0.addr[AW-1:2]] <= (r0.wdata & ~z0[r0.addr[AW-1:2]])
                               | o0[r0.addr[AW-1:2]];
      else
        r0.rdata <= (m0[r0.addr[AW-1:2]] & ~z0[r0.addr[AW-1:2]])
                    | o0[r0.addr[AW-1:2]];
    end
  end

  always @(posedge clk) begin
    if (r1.en) begin
      if (r1.we)
        m1[r1.addr[AW-1:2]] <= r1.wdata & ~z1[r1.addr[AW-1:2]];
      else
        r1.rdata <= m1[r1.addr[AW-1:2]] & ~z1[r1.addr[AW-1:2]];
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   d;
  } op_s;

  op_s eops[$];

  task automatic build_ops(input logic [31:0] pat);
    logic up;
    int w;
    logic [31:0] zr, on;
    zr = pat;
    on = ~pat;
    eops.delete();
    for (int e = 0; e < 6; e++) begin
      up = (e == 0) || (e == 1) || (e == 2) || (e == 5);
      for (int i = 0; i < N; i++) begin
        w = up ? i : N - 1 - i;
        case (e)
          0: eops.push_back('{1'b1, AW'(4*w), zr});
          1: begin
            eops.push_back('{1'b0, AW'(4*w), zr});
            eops.push_back('{1'b1, AW'(4*w), on});
          end
          2: begin
            eops.push_back('{1'b0, AW'(4*w), on});
            eops.push_back('{1'b1, AW'(4*w), zr});
          end
          3: begin
            eops.push_back('{1'b0, AW'(4*w), zr});
            eops.push_back('{1'b1, AW'(4*w), on});
          end
          4: begin
            eops.push_back('{1'b0, AW'(4*w), on});
            eops.push_back('{1'b1, AW'(4*w), zr});
          end
          default: eops.push_back('{1'b0, AW'(4*w), zr});
        endcase
      end
    end
  endtask

  task automatic predict(input logic [31:0] pat, input bit sel,
                         output logic f, output logic [AW-1:0] fa);
    logic [31:0] mem [N];
    logic [31:0] zm, om, got;
    int w;
    build_ops(pat);
    f = 1'b0;
    fa = '0;
    for (int k = 0; k < N; k++) mem[k] = '0;
    foreach (eops[i]) begin
      w = int'(eops[i].addr) / 4;
      zm = sel ? z1[w] : z0[w];
      om = sel ? 32'h0 : o0[w];
      if (eops[i].we) begin
        mem[w] = (eops[i].d & ~zm) | om;
      end else begin
        got = (mem[w] & ~zm) | om;
        if (got != eops[i].d && !f) begin
          f = 1'b1;
          fa = eops[i].addr;
        end
      end
    end
  endtask

  int done_at, busy_cnt, nops, nwr, nrd, seq_err, idle_err;
  logic done_j0, timeout;
  logic [AW-1:0] seen_addr [10*N];
  logic seen_we [10*N];

  task automatic run0(input int hold, input int pulse_at);
    op_s e;
    build_ops(32'h0);
    done_at = -1; busy_cnt = 0; nops = 0; nwr = 0; nrd = 0;
    seq_err = 0; idle_err = 0; timeout = 1'b1; done_j0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 400; j++) begin
      if (j > 0) @(posedge clk);
      @(negedge clk);
      if (j == hold - 1) start0 = 1'b0;
      if (pulse_at > 0 && j == pulse_at) start0 = 1'b1;
      if (pulse_at > 0 && j == pulse_at + 1) start0 = 1'b0;
      if (j == 0) done_j0 = done0;
      if (busy0) busy_cnt++;
      if (r0.en) begin
        if (nops < 10*N) begin
          e = eops[nops];
          if (r0.we !== e.we || r0.addr !== e.addr ||
              r0.be !== 4'hF || (e.we && r0.wdata !== e.d))
            seq_err++;
          seen_addr[nops] = r0.addr;
          seen_we[nops] = r0.we;
        end
        if (r0.we) nwr++; else nrd++;
        nops++;
      end else if (r0.be !== 4'h0 || r0.we !== 1'b0 ||
                   r0.wdata !== 32'h0) begin
        idle_err++;
      end
      if (done0) begin
        done_at = j;
        timeout = 1'b0;
        break;
      end
    end
    start0 = 1'b0;
  endtask

  task automatic clear_faults();
    for (int k = 0; k < N; k++) begin
      z0[k] = '0; o0[k] = '0; z1[k] = '0;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy0, done0, fail0, fa0} !== '0) begin
      bad++;
      $display("FAIL reset_status got=%b exp=0",
               {busy0, done0, fail0, fa0});
    end
    total++;
    if ({r0.en, r0.we, r0.be, r0.wdata, r0.addr} !== '0) begin
      bad++;
      $display("FAIL reset_bus got=%h exp=0",
               {r0.en, r0.we, r0.be, r0.wdata, r0.addr});
    end
  endtask

  task automatic test_fault_free();
    clear_faults();
    run0(1, 0);
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL ff_timeout got=%b exp=0", timeout);
    end
    total++;
    if (busy_cnt !== 162) begin
      bad++; $display("FAIL ff_busy got=%0d exp=162", busy_cnt);
    end
    total++;
    if (done_at !== 162) begin
      bad++; $display("FAIL ff_done got=%0d exp=162", done_at);
    end
    total++;
    if (fail0 !== 1'b0) begin
      bad++; $display("FAIL ff_fail got=%b exp=0", fail0);
    end
    total++;
    if (nops !== 160) begin
      bad++; $display("FAIL ff_ops got=%0d exp=160", nops);
    end
    total++;
    if (nwr !== 80 || nrd !== 80) begin
      bad++;
      $display("FAIL ff_wr_rd got=%0d/%0d exp=80/80", nwr, nrd);
    end
    total++;
    if (seq_err !== 0) begin
      bad++; $display("FAIL ff_seq got=%0d exp=0", seq_err);
    end
    total++;
    if (idle_err !== 0) begin
      bad++; $display("FAIL ff_idle got=%0d exp=0", idle_err);
    end
  endtask

  task automatic test_addr_order();
    total++;
    if (seen_addr[0] !== 6'h00 || seen_addr[1] !== 6'h04) begin
      bad++;
      $display("FAIL e0_start got=%h,%h exp=00,04",
               seen_addr[0], seen_addr[1]);
    end
    total++;
    if (seen_addr[15] !== 6'h3C || seen_we[15] !== 1'b1) begin
      bad++;
      $display("FAIL e0_end got=%h we=%b exp=3c we=1",
               seen_addr[15], seen_we[15]);
    end
    total++;
    if (seen_addr[80] !== 6'h3C || seen_we[80] !== 1'b0) begin
      bad++;
      $display("FAIL e3_first got=%h we=%b exp=3c we=0",
               seen_addr[80], seen_we[80]);
    end
    total++;
    if (seen_addr[81] !== 6'h3C || seen_addr[82] !== 6'h38) begin
      bad++;
      $display("FAIL e3_down got=%h,%h exp=3c,38",
               seen_addr[81], seen_addr[82]);
    end
    total++;
    if (seen_addr[159] !== 6'h3C || seen_we[159] !== 1'b0) begin
      bad++;
      $display("FAIL e5_end got=%h we=%b exp=3c we=0",
               seen_addr[159], seen_we[159]);
    end
  endtask

  task automatic test_stuck_bit();
    clear_faults();
    z0[5] = 32'h0000_0008;
    run0(1, 0);
    total++;
    if (fail0 !== 1'b1 || fa0 !== 6'h14) begin
      bad++;
      $display("FAIL stuck_addr got=%b/%h exp=1/14", fail0, fa0);
    end
    total++;
    if (done_at !== 162) begin
      bad++; $display("FAIL stuck_done got=%0d exp=162", done_at);
    end
  endtask

  task automatic test_two_faults();
    clear_faults();
    z0[5] = 32'h0000_0008;
    z0[2] = 32'h0002_0000;
    run0(1, 0);
    total++;
    if (fail0 !== 1'b1 || fa0 !== 6'h08) begin
      bad++;
      $display("FAIL two_first got=%b/%h exp=1/08", fail0, fa0);
    end
    clear_faults();
    run0(1, 0);
    total++;
    if (fail0 !== 1'b0 || fa0 !== 6'h00) begin
      bad++;
      $display("FAIL rerun_clear got=%b/%h exp=0/00", fail0, fa0);
    end
    total++;
    if (done_at !== 162) begin
      bad++; $display("FAIL rerun_done got=%0d exp=162", done_at);
    end
  endtask

  task automatic test_reset_midrun();
    clear_faults();
    z0[1] = 32'h1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if ({busy0, done0, fail0, fa0} !== '0) begin
      bad++;
      $display("FAIL mid_status got=%b exp=0",
               {busy0, done0, fail0, fa0});
    end
    total++;
    if ({r0.en, r0.we, r0.be, r0.wdata, r0.addr} !== '0) begin
      bad++;
      $display("FAIL mid_bus got=%h exp=0",
               {r0.en, r0.we, r0.be, r0.wdata, r0.addr});
    end
    @(negedge clk);
    rstn = 1'b1;
    clear_faults();
    run0(1, 0);
    total++;
    if (done_at !== 162 || fail0 !== 1'b0 || seq_err !== 0) begin
      bad++;
      $display("FAIL mid_rerun got=%0d/%b/%0d exp=162/0/0",
               done_at, fail0, seq_err);
    end
  endtask

  task automatic test_start_ignored();
    clear_faults();
    run0(1, 40);
    total++;
    if (done_at !== 162 || busy_cnt !== 162) begin
      bad++;
      $display("FAIL ign_timing got=%0d/%0d exp=162/162",
               done_at, busy_cnt);
    end
    total++;
    if (seq_err !== 0 || nops !== 160) begin
      bad++;
      $display("FAIL ign_seq got=%0d/%0d exp=0/160", seq_err, nops);
    end
  endtask

  task automatic test_restart_held();
    total++;
    if (done0 !== 1'b1) begin
      bad++; $display("FAIL held_pre got=%b exp=1", done0);
    end
    run0(3, 0);
    total++;
    if (done_j0 !== 1'b0) begin
      bad++; $display("FAIL held_drop got=%b exp=0", done_j0);
    end
    total++;
    if (done_at !== 162 || nops !== 160 || seq_err !== 0) begin
      bad++;
      $display("FAIL held_run got=%0d/%0d/%0d exp=162/160/0",
               done_at, nops, seq_err);
    end
  endtask

  task automatic test_random_faults();
    logic pf;
    logic [AW-1:0] pa;
    int nf, w;
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        w = $urandom_range(0, N-1);
        if ($urandom_range(0, 1) == 0)
          z0[w] = z0[w] | (32'h1 << $urandom_range(0, 31));
        else
          o0[w] = o0[w] | (32'h1 << $urandom_range(0, 31));
      end
      predict(32'h0, 1'b0, pf, pa);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run0(1, 0);
      total++;
      if (fail0 !== pf) begin
        bad++;
        $display("FAIL rnd%0d_fail got=%b exp=%b", it, fail0, pf);
      end
      total++;
      if (fa0 !== pa) begin
        bad++;
        $display("FAIL rnd%0d_addr got=%h exp=%h", it, fa0, pa);
      end
      total++;
      if (done_at !== 162) begin
        bad++;
        $display("FAIL rnd%0d_done got=%0d exp=162", it, done_at);
      end
    end
  endtask

  task automatic test_pattern();
    logic pf;
    logic [AW-1:0] pa;
    logic [31:0] wd0, wd1;
    int n, d_at;
    clear_faults();
    z1[3] = 32'h0000_0002;
    predict(PAT1, 1'b1, pf, pa);
    n = 0; d_at = -1; wd0 = '0; wd1 = '0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 400; j++) begin
      if (j > 0) @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      if (r1.en) begin
        if (n == 0) wd0 = r1.wdata;
        if (n == N + 1) wd1 = r1.wdata;
        n++;
      end
      if (done1) begin
        d_at = j;
        break;
      end
    end
    total++;
    if (wd0 !== PAT1) begin
      bad++; $display("FAIL pat_w0 got=%h exp=%h", wd0, PAT1);
    end
    total++;
    if (wd1 !== 32'hAAAA_AAAA) begin
      bad++; $display("FAIL pat_w1 got=%h exp=aaaaaaaa", wd1);
    end
    total++;
    if (d_at !== 162) begin
      bad++; $display("FAIL pat_done got=%0d exp=162", d_at);
    end
    total++;
    if (fail1 !== 1'b1 || fa1 !== 6'h0C) begin
      bad++;
      $display("FAIL pat_r1 got=%b/%h exp=1/0c", fail1, fa1);
    end
    total++;
    if (fail1 !== pf || fa1 !== pa) begin
      bad++;
      $display("FAIL pat_model got=%b/%h exp=%b/%h",
               fail1, fa1, pf, pa);
    end
  endtask

  initial begin
    clear_faults();
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    test_fault_free();
    test_addr_order();
    test_stuck_bit();
    test_two_faults();
    test_reset_midrun();
    test_start_ignored();
    test_restart_held();
    test_random_faults();
    test_pattern();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
